pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Generates the write-enable, hold and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Covers load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses through a req/ack handshake with timeout. Sits beside the datapath and takes its inputs from the ID/EX and EX/MEM register outputs.

## Interface
- TIMEOUT_W, default 4: width of the memory-wait counter; timeout fires after 2^TIMEOUT_W−1 wait cycles.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  load destination register in EX.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
- exmem_memread, exmem_memwrite  in  1 each  instruction in MEM accesses data memory.
- branch_taken  in  1  branch in MEM is taken.
- dmem_ack  in  1  data memory completes the current access.
- dmem_req  out  1  access request to data memory.
- pc_write, ifid_write  out  1 each  PC / IF/ID load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that register.
- exmem_hold  out  1  EX/MEM keeps its contents.
- memwb_bubble  out  1  MEM/WB loads a bubble.
- mem_err  out  1  sticky memory-timeout error.
- stall_cycles, flush_count  out  32 each  performance counters.

## Operation
- FSM states: RUN, MEMWAIT, ERR. Reset state is RUN. Outputs are Mealy, derived from the state and the current inputs.
- While rst=0: every output is 0, the wait counter is 0, mem_err is 0, and both perf counters are 0.
- **RUN defaults:** pc_write=1, ifid_write=1; all other outputs 0.
- **RUN priority:** memory access first, then branch, then load-use.
  - Memory access (exmem_memread|exmem_memwrite):
    - dmem_req=1 in the same cycle.
    - If dmem_ack=1 in that cycle, there is no stall.
    - Otherwise: pc_write=0, ifid_write=0, exmem_hold=1, memwb_bubble=1, and the next state is MEMWAIT.
    - If branch_taken is also asserted, the flush is deferred until the ack cycle. Inputs are stable because EX/MEM is held.
  - Branch (branch_taken, no pending access): ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1.
  - Load-use: condition is idex_memread and idex_rt≠0 and (idex_rt==ifid_rs or idex_rt==ifid_rt). Response is pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle.
- **MEMWAIT:**
  - Each cycle: dmem_req=1, stall outputs as above, wait counter +1.
  - On dmem_ack: the outputs in that cycle are the RUN values, including any deferred branch flush. Next state is RUN and the counter clears.
  - Load-use is not evaluated in MEMWAIT.
  - Counter reaching 2^TIMEOUT_W−1 with no ack: next state is ERR.
- **ERR:**
  - mem_err=1; pc_write=0, ifid_write=0, exmem_hold=1, memwb_bubble=1, dmem_req=0.
  - Left only by reset. A late dmem_ack is ignored.

## Timing
- Hazard response has 0-cycle latency (combinational) from the inputs in RUN.
- A memory access acked after N cycles (N≥1 cycles after the request) produces N stall cycles. dmem_req is high for N+1 cycles.
- Handshake:
  - dmem_req stays high until ack is sampled.
  - ack is a single-cycle pulse.
  - ack with req low is ignored.
- Asynchronous reset mid-MEMWAIT: outputs go to 0 immediately and dmem_req drops. The state is RUN after release.
- The wait counter is TIMEOUT_W bits, cleared on entering and leaving MEMWAIT, with no wrap.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every post-reset cycle with pc_write=0.
  - flush_count increments on every cycle with exmem_flush=1.
  - Both saturate at 2^32−1.
- HAZARD_PERF_EN undefined: both ports remain and are tied to 0; no counter logic is built.

## Test plan
- Reset: rst=0 with arbitrary inputs → all outputs 0. After release with idle inputs → pc_write=1, ifid_write=1, rest 0.
- Load-use:
  - idex_memread=1, idex_rt=5, ifid_rs=5 → one cycle of pc_write=0, idex_flush=1.
  - Same with idex_rt=0 → no stall.
- Memory wait: exmem_memread=1, dmem_ack on the 4th cycle → dmem_req high 4 cycles, exmem_hold 3 cycles, RUN on the ack cycle.
- Timeout: TIMEOUT_W=4, no ack → mem_err=1 after 15 MEMWAIT cycles. A later ack leaves it set; rst=0 clears it.
- Simultaneous events:
  - branch_taken=1 together with a load-use match → flushes=1, pc_write=1, no load-use stall.
  - branch_taken with a pending store acked after 2 cycles → flush asserted only in the ack cycle.
- Perf, with HAZARD_PERF_EN: one 3-cycle wait, one load-use and one branch → stall_cycles=4, flush_count=1. Without the macro → both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, MEM-stage branch flush and dmem req/ack wait with timeout.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    input  logic        branch_taken,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        exmem_hold,
    output logic        memwb_bubble,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        ERR
    } state_e;

    // Last MEMWAIT cycle that may still see an ack is count 2^W-2, giving 2^W-1 wait cycles.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 mem_access;
    logic                 load_use;

    assign mem_access = exmem_memread | exmem_memwrite;
    assign load_use   = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        dmem_req     = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        mem_err      = 1'b0;

        if (rst) begin
            unique case (state_q)
                RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    dmem_req   = mem_access;
                    if (mem_access && !dmem_ack) begin
                        // Branch flush waits for the ack cycle; EX/MEM is held so it stays visible.
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        exmem_hold   = 1'b1;
                        memwb_bubble = 1'b1;
                        state_d      = MEMWAIT;
                        wait_d       = '0;
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEMWAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = branch_taken;
                        idex_flush  = branch_taken;
                        exmem_flush = branch_taken;
                        state_d     = RUN;
                        wait_d      = '0;
                    end else begin
                        exmem_hold   = 1'b1;
                        memwb_bubble = 1'b1;
                        if (wait_q == WAIT_LAST) begin
                            state_d = ERR;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
                ERR: begin
                    mem_err      = 1'b1;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (exmem_flush && (flush_q != '1)) flush_d = flush_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences,
// and randomized traffic against a behavioural model. Perf expectations follow HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        exmem_memread, exmem_memwrite, branch_taken, dmem_ack;
    logic        dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic        exmem_hold, memwb_bubble, mem_err;
    logic [31:0] stall_cycles, flush_count;
    logic [8:0]  outs;

    int tests  = 0;
    int failed = 0;

    // Output vector order: req pc ifid_w ifid_fl idex_fl exmem_fl hold bubble err
    localparam logic [8:0] IDLE  = 9'b011000000;
    localparam logic [8:0] LU    = 9'b000010000;
    localparam logic [8:0] BR    = 9'b011111000;
    localparam logic [8:0] STALL = 9'b100000110;
    localparam logic [8:0] ACK   = 9'b111000000;
    localparam logic [8:0] ACKBR = 9'b111111000;
    localparam logic [8:0] ERRO  = 9'b000000111;

    pipe_hazard_ctrl #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .branch_taken(branch_taken), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign outs = {dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
                   exmem_hold, memwb_bubble, mem_err};

    typedef struct {
        logic       rst;
        logic       idex_memread;
        logic [4:0] idex_rt;
        logic [4:0] ifid_rs;
        logic [4:0] ifid_rt;
        logic       exmem_memread;
        logic       exmem_memwrite;
        logic       branch_taken;
        logic       dmem_ack;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[8];

    // Behavioural reference state
    bit     m_wait, m_err;
    int     m_waited;
    longint m_stall, m_flush;

    task automatic chk(input string name, input logic [8:0] exp);
        tests++;
        if (outs !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, outs, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        idex_memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0; branch_taken = 1'b0; dmem_ack = 1'b0;
    endtask

    // Inputs were driven at posedge+1; sample mid-cycle, then advance to next posedge+1.
    task automatic step(input string name, input logic [8:0] exp);
        #3;
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        #3;
        chk("reset_outs", 9'b0);
        chk32("reset_stall", stall_cycles, 32'd0);
        chk32("reset_flush", flush_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_cycle(output logic [8:0] e);
        bit acc, lu, req, stall, fl, luh;
        acc = exmem_memread | exmem_memwrite;
        lu  = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (m_err) begin
            e = ERRO;
        end else begin
            req   = m_wait || acc;
            stall = req && !dmem_ack;
            fl    = !stall && branch_taken;
            luh   = !stall && !fl && !m_wait && lu;
            e = {req, !(stall || luh), !(stall || luh), fl, fl || luh, fl, stall, stall, 1'b0};
            if (!stall) m_wait = 0;
            else if (!m_wait) begin m_wait = 1; m_waited = 0; end
            else begin
                m_waited++;
                if (m_waited == 15) m_err = 1;
            end
        end
        if (!e[7]) m_stall++;
        if (e[3]) m_flush++;
    endtask

    initial begin
        int req_n, hold_n;
        logic [8:0] e;

        rst = 1'b0;
        idle_inputs();
        vecs[0] = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9'b0};
        vecs[1] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[2] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[3] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[4] = '{1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[5] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BR};
        vecs[6] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, ACK};
        vecs[7] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, ACKBR};

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst;
            idex_memread = vecs[i].idex_memread; idex_rt = vecs[i].idex_rt;
            ifid_rs = vecs[i].ifid_rs; ifid_rt = vecs[i].ifid_rt;
            exmem_memread = vecs[i].exmem_memread; exmem_memwrite = vecs[i].exmem_memwrite;
            branch_taken = vecs[i].branch_taken; dmem_ack = vecs[i].dmem_ack;
            step($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Memory read acked on the 4th request cycle
        do_reset();
        req_n = 0; hold_n = 0;
        exmem_memread = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            dmem_ack = (c == 4);
            #3;
            req_n  += int'(dmem_req);
            hold_n += int'(exmem_hold);
            #(-3 + 3);
            step($sformatf("memwait_c%0d", c), (c == 4) ? ACK : STALL);
        end
        tests++;
        if (req_n != 4 || hold_n != 3) begin
            failed++;
            $display("FAIL memwait_counts: req=%0d hold=%0d expected req=4 hold=3", req_n, hold_n);
        end
        idle_inputs();
        step("memwait_back_run", IDLE);

        // Timeout: 1 request cycle + 15 MEMWAIT cycles, then ERR
        do_reset();
        exmem_memread = 1'b1;
        for (int c = 0; c < 16; c++) step($sformatf("timeout_wait%0d", c), STALL);
        step("timeout_err", ERRO);
        dmem_ack = 1'b1;
        step("err_late_ack", ERRO);
        idle_inputs();
        step("err_sticky", ERRO);

        // Store with taken branch, acked after 2 cycles: flush only in ack cycle
        do_reset();
        exmem_memwrite = 1'b1; branch_taken = 1'b1;
        step("stbr_c1", STALL);
        step("stbr_c2", STALL);
        dmem_ack = 1'b1;
        step("stbr_ack", ACKBR);
        idle_inputs();
        step("stbr_after", IDLE);

        // Asynchronous reset while waiting
        do_reset();
        exmem_memread = 1'b1;
        step("areset_c1", STALL);
        #3;
        chk("areset_wait", STALL);
        rst = 1'b0;
        #1;
        chk("areset_now", 9'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        step("areset_release", IDLE);

        // Perf: load-use, branch, 3-cycle wait
        do_reset();
        idex_memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
        step("perf_lu", LU);
        idle_inputs(); branch_taken = 1'b1;
        step("perf_br", BR);
        idle_inputs(); exmem_memread = 1'b1;
        step("perf_m1", STALL);
        step("perf_m2", STALL);
        step("perf_m3", STALL);
        dmem_ack = 1'b1;
        step("perf_ack", ACK);
        idle_inputs();
        #3;
`ifdef HAZARD_PERF_EN
        chk32("perf_stall", stall_cycles, 32'd4);
        chk32("perf_flush", flush_count, 32'd1);
`else
        chk32("perf_stall", stall_cycles, 32'd0);
        chk32("perf_flush", flush_count, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Randomized traffic against the behavioural model
        for (int seg = 0; seg < 20; seg++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                idex_memread   = 1'($urandom_range(1));
                idex_rt        = 5'($urandom_range(3));
                ifid_rs        = 5'($urandom_range(3));
                ifid_rt        = 5'($urandom_range(3));
                exmem_memread  = ($urandom_range(3) == 0);
                exmem_memwrite = ($urandom_range(7) == 0);
                branch_taken   = ($urandom_range(3) == 0);
                dmem_ack       = ($urandom_range(2) == 0);
                model_cycle(e);
                step("rand", e);
            end
            #3;
`ifdef HAZARD_PERF_EN
            chk32("rand_stall", stall_cycles, 32'(m_stall));
            chk32("rand_flush", flush_count, 32'(m_flush));
`else
            chk32("rand_stall", stall_cycles, 32'd0);
            chk32("rand_flush", flush_count, 32'd0);
`endif
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
